// File: rtl/pulse_cmd_regs_pkg.sv
// ----------------------------------------------------------------------------
// pulse_cmd_regs_pkg
//   Shared definitions for the UART-driven pulse-parameter register block:
//   controller state encoding, control-byte field layout and the helper that
//   sizes a command response.
// ----------------------------------------------------------------------------
package pulse_cmd_regs_pkg;

    typedef enum logic [2:0] {
        ST_RX      = 3'd0,
        ST_EXEC    = 3'd1,
        ST_TX_LOAD = 3'd2,
        ST_TX_ARM  = 3'd3,
        ST_TX_WAIT = 3'd4
    } state_t;

    // Control byte layout: [7] = read flag, [6:0] = register address.
    localparam int READ_BIT = 7;
    localparam int ADDR_W   = 7;

    // A valid read returns the whole word plus its checksum; every other
    // command answers with a single status byte.
    function automatic int resp_bytes(input logic is_read, input logic addr_ok,
                                      input int word_bytes);
        return (is_read && addr_ok) ? word_bytes + 1 : 1;
    endfunction

endpackage

// File: rtl/pulse_cmd_timeout.sv
// ----------------------------------------------------------------------------
// pulse_cmd_timeout
//   Idle counter for partially received frames. Counts enabled clocks and
//   emits a one-cycle expire pulse once TIMEOUT_CYCLES idle clocks have
//   elapsed, then restarts from zero.
//
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   clr_i     in   hold counter at zero (byte received / no partial frame)
//   en_i      in   count this clock
//   expire_o  out  combinational pulse on the final idle clock
// ----------------------------------------------------------------------------
module pulse_cmd_timeout #(
    parameter int TIMEOUT_CYCLES = 1200000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] idle_q;

    assign expire_o = en_i && !clr_i && (idle_q == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr_i || expire_o) begin
            idle_q <= '0;
        end else if (en_i) begin
            idle_q <= idle_q + 1'b1;
        end
    end

endmodule

// File: rtl/pulse_cmd_regs.sv
// ----------------------------------------------------------------------------
// pulse_cmd_regs
//   Register file of pulse parameters controlled over a byte stream (UART).
//   A frame is WORD_BYTES data bytes (LSB first) followed by a control byte
//   (bit 7 = read, bits 6:0 = address). Writes answer with the data checksum,
//   reads answer with the register bytes plus their checksum, and an
//   out-of-range address answers with the inverted data checksum.
//
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   rx_valid     in   one-cycle strobe, rx_byte valid
//   rx_byte      in   received byte
//   tx_busy      in   UART transmitter busy
//   tx_start     out  one-cycle transmit request
//   tx_byte      out  byte to transmit, held until the next request
//   regs         out  flat register file, register i at slice i
//   upd          out  one-cycle strobe per register, cycle after its write
//   err_timeout  out  partial frame discarded after idle timeout
//   err_overrun  out  byte arrived while a command was being serviced
// ----------------------------------------------------------------------------
module pulse_cmd_regs
    import pulse_cmd_regs_pkg::*;
#(
    parameter int NUM_REGS       = 8,
    parameter int WORD_BYTES     = 4,
    parameter int TIMEOUT_CYCLES = 1200000,
    parameter logic [NUM_REGS*8*WORD_BYTES-1:0] RESET_VALUES = '0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             rx_valid,
    input  logic [7:0]                       rx_byte,
    input  logic                             tx_busy,
    output logic                             tx_start,
    output logic [7:0]                       tx_byte,
    output logic [NUM_REGS*8*WORD_BYTES-1:0] regs,
    output logic [NUM_REGS-1:0]              upd,
    output logic                             err_timeout,
    output logic                             err_overrun
);

    localparam int WW = 8 * WORD_BYTES;
    localparam int CW = $clog2(WORD_BYTES + 1);
    localparam int RW = 8 * (WORD_BYTES + 1);

    state_t              state_q;
    logic [CW-1:0]       cnt_q;
    logic [CW-1:0]       tx_idx_q;
    logic [CW-1:0]       tx_last_q;
    logic [WW-1:0]       data_q;
    logic [7:0]          ctrl_q;
    logic [RW-1:0]       resp_q;
    logic [WW-1:0]       regs_q [NUM_REGS];
    logic                tx_start_q;
    logic [7:0]          tx_byte_q;
    logic [NUM_REGS-1:0] upd_q;
    logic                err_timeout_q;
    logic                err_overrun_q;

    logic [ADDR_W-1:0]   addr;
    logic                is_read;
    logic                addr_ok;
    logic [WW-1:0]       rd_word_d;
    logic [7:0]          data_sum_d;
    logic [7:0]          rd_sum_d;
    logic [RW-1:0]       resp_d;
    logic [CW-1:0]       tx_last_d;
    logic                tmo_clr;
    logic                tmo_en;
    logic                tmo_expire;

    function automatic logic [7:0] byte_sum(input logic [WW-1:0] w);
        logic [7:0] s;
        s = '0;
        for (int b = 0; b < WORD_BYTES; b++) begin
            s = s + w[8*b +: 8];
        end
        return s;
    endfunction

    assign addr    = ctrl_q[ADDR_W-1:0];
    assign is_read = ctrl_q[READ_BIT];
    assign addr_ok = (int'(addr) < NUM_REGS);

    // Read mux written as a compare loop so the 7-bit address never indexes
    // the array directly when NUM_REGS is smaller than 128.
    always_comb begin
        rd_word_d = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr == ADDR_W'(i)) begin
                rd_word_d = regs_q[i];
            end
        end
    end

    assign data_sum_d = byte_sum(data_q);
    assign rd_sum_d   = byte_sum(rd_word_d);
    assign tx_last_d  = CW'(resp_bytes(is_read, addr_ok, WORD_BYTES) - 1);

    always_comb begin
        resp_d = '0;
        if (!addr_ok) begin
            resp_d[7:0] = ~data_sum_d;
        end else if (is_read) begin
            resp_d[WW-1:0]   = rd_word_d;
            resp_d[RW-1 -: 8] = rd_sum_d;
        end else begin
            resp_d[7:0] = data_sum_d;
        end
    end

    // Idle timer only runs while a frame is partially received.
    assign tmo_clr = rx_valid || (cnt_q == '0) || (state_q != ST_RX);
    assign tmo_en  = (state_q == ST_RX);

    pulse_cmd_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (tmo_clr),
        .en_i     (tmo_en),
        .expire_o (tmo_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RX;
            cnt_q         <= '0;
            tx_idx_q      <= '0;
            tx_last_q     <= '0;
            tx_start_q    <= 1'b0;
            tx_byte_q     <= '0;
            upd_q         <= '0;
            err_timeout_q <= 1'b0;
            err_overrun_q <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= RESET_VALUES[WW*i +: WW];
            end
        end else begin
            tx_start_q    <= 1'b0;
            upd_q         <= '0;
            err_timeout_q <= 1'b0;
            err_overrun_q <= rx_valid && (state_q != ST_RX);

            case (state_q)
                ST_RX: begin
                    if (rx_valid) begin
                        if (cnt_q == CW'(WORD_BYTES)) begin
                            ctrl_q  <= rx_byte;
                            cnt_q   <= '0;
                            state_q <= ST_EXEC;
                        end else begin
                            data_q[8*int'(cnt_q) +: 8] <= rx_byte;
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end else if (tmo_expire) begin
                        cnt_q         <= '0;
                        err_timeout_q <= 1'b1;
                    end
                end

                ST_EXEC: begin
                    resp_q    <= resp_d;
                    tx_last_q <= tx_last_d;
                    tx_idx_q  <= '0;
                    if (addr_ok && !is_read) begin
                        for (int i = 0; i < NUM_REGS; i++) begin
                            if (addr == ADDR_W'(i)) begin
                                regs_q[i] <= data_q;
                                upd_q[i]  <= 1'b1;
                            end
                        end
                    end
                    state_q <= ST_TX_LOAD;
                end

                ST_TX_LOAD: begin
                    if (!tx_busy) begin
                        tx_byte_q  <= resp_q[8*int'(tx_idx_q) +: 8];
                        tx_start_q <= 1'b1;
                        state_q    <= ST_TX_ARM;
                    end
                end

                // Give the transmitter a cycle to raise busy before polling it.
                ST_TX_ARM: begin
                    state_q <= ST_TX_WAIT;
                end

                ST_TX_WAIT: begin
                    if (!tx_busy) begin
                        if (tx_idx_q == tx_last_q) begin
                            state_q <= ST_RX;
                        end else begin
                            tx_idx_q <= tx_idx_q + 1'b1;
                            state_q  <= ST_TX_LOAD;
                        end
                    end
                end

                default: begin
                    state_q <= ST_RX;
                end
            endcase
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
        assign regs[WW*g +: WW] = regs_q[g];
    end

    assign tx_start    = tx_start_q;
    assign tx_byte     = tx_byte_q;
    assign upd         = upd_q;
    assign err_timeout = err_timeout_q;
    assign err_overrun = err_overrun_q;

endmodule
